// File: rtl/branch_pc_unit_if.sv
// Control/status bundle between a sequencer front end and branch_pc_unit.
// Carries enable, branch/call/return requests, compare-flag writes and PC status.
// master drives requests and observes status; slave is the PC unit itself.
interface branch_pc_unit_if #(
    parameter int PC_W     = 10,
    parameter int OFFSET_W = 8
);
    // requests into the PC unit
    logic                en;
    logic [1:0]          cond_sel;
    logic                abs_mode;
    logic [OFFSET_W-1:0] offset;
    logic [PC_W-1:0]     target;
    logic                call;
    logic                ret;
    logic                flag_we;
    logic [2:0]          flag_in;
    logic                err_clr;

    // status out of the PC unit
    logic [PC_W-1:0]     pc;
    logic [2:0]          flags;
    logic                taken;
    logic                ras_empty;
    logic                ras_full;
    logic                err;

    modport master (
        output en, cond_sel, abs_mode, offset, target, call, ret,
               flag_we, flag_in, err_clr,
        input  pc, flags, taken, ras_empty, ras_full, err
    );

    modport slave (
        input  en, cond_sel, abs_mode, offset, target, call, ret,
               flag_we, flag_in, err_clr,
        output pc, flags, taken, ras_empty, ras_full, err
    );
endinterface

// File: rtl/branch_pc_unit.sv
// Program counter with conditional relative/absolute branches, call/return stack and sticky error.
// Latency: one edge; pc/flags/taken/err are registered, ras_empty/ras_full decode the occupancy count.
// Backpressure: en=0 stalls pc and stack and drops requests; flags and err keep updating.
module branch_pc_unit #(
    parameter int          PC_W       = 10,
    parameter int          OFFSET_W   = 8,
    parameter int          RAS_DEPTH  = 4,
    parameter int unsigned START_ADDR = 0
) (
    input logic             clk,
    input logic             reset,
    branch_pc_unit_if.slave bus
);

    // Condition encoding on cond_sel
    localparam logic [1:0] COND_NONE = 2'b00;
    localparam logic [1:0] COND_EQ   = 2'b01;
    localparam logic [1:0] COND_LT   = 2'b10;
    localparam logic [1:0] COND_GT   = 2'b11;

    // Flag bit positions inside {gt, lt, eq}
    localparam int FLAG_EQ = 0;
    localparam int FLAG_LT = 1;
    localparam int FLAG_GT = 2;

    // Occupancy counts 0..RAS_DEPTH inclusive, so it needs one more code than the index
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PC_W-1:0]  PC_RESET  = PC_W'(START_ADDR);
    localparam logic [PC_W-1:0]  PC_ONE    = PC_W'(1);

    // Architectural state
    logic [PC_W-1:0]  pc_q;
    logic [2:0]       flags_q;
    logic             taken_q;
    logic             err_q;
    logic [CNT_W-1:0] occ_q;

    // Return-address storage; contents are meaningless above the occupancy count
    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];

    // Next-state decode
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  pc_rel;
    logic [PC_W-1:0]  offset_ext;
    logic [PC_W-1:0]  pc_next;
    logic             taken_next;
    logic             cond_hit;
    logic             stack_empty;
    logic             stack_full;
    logic             push;
    logic             pop;
    logic             err_set;
    logic [CNT_W-1:0] occ_dec;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] top_idx;
    logic [PC_W-1:0]  top_val;

    assign stack_empty = (occ_q == CNT_ZERO);
    assign stack_full  = (occ_q == CNT_FULL);

    // Push goes to the slot at the current count, pop reads the slot below it
    assign occ_dec  = occ_q - CNT_ONE;
    assign push_idx = occ_q[IDX_W-1:0];
    assign top_idx  = occ_dec[IDX_W-1:0];
    assign top_val  = ras_mem[top_idx];

    // Offset is two's complement; widen with its sign so backward branches wrap correctly
    assign offset_ext = PC_W'(signed'(bus.offset));
    assign pc_inc     = pc_q + PC_ONE;
    assign pc_rel     = pc_q + offset_ext;

    // Branch condition uses the flags held before this edge, never the same-edge flag_in
    always_comb begin
        cond_hit = 1'b0;
        case (bus.cond_sel)
            COND_NONE: cond_hit = 1'b0;
            COND_EQ:   cond_hit = flags_q[FLAG_EQ];
            COND_LT:   cond_hit = flags_q[FLAG_LT];
            COND_GT:   cond_hit = flags_q[FLAG_GT];
            default:   cond_hit = 1'b0;
        endcase
    end

    // One action per enabled edge: conflict, then ret, then call, then branch, else step
    always_comb begin
        pc_next    = pc_q;
        taken_next = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        err_set    = 1'b0;
        if (bus.en) begin
            pc_next = pc_inc;
            if (bus.call && bus.ret) begin
                // Ambiguous request: touch nothing on the stack, just step and flag it
                err_set = 1'b1;
            end else if (bus.ret) begin
                if (stack_empty) begin
                    err_set = 1'b1;
                end else begin
                    pop        = 1'b1;
                    pc_next    = top_val;
                    taken_next = 1'b1;
                end
            end else if (bus.call) begin
                // The jump happens even on overflow; only the return address is lost
                pc_next    = bus.target;
                taken_next = 1'b1;
                if (stack_full) begin
                    err_set = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end else if (cond_hit) begin
                pc_next    = bus.abs_mode ? bus.target : pc_rel;
                taken_next = 1'b1;
            end
        end
    end

    // Program counter, redirect pulse and stack occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= PC_RESET;
            taken_q <= 1'b0;
            occ_q   <= CNT_ZERO;
        end else begin
            pc_q    <= pc_next;
            taken_q <= taken_next;
            if (push) begin
                occ_q <= occ_q + CNT_ONE;
            end else if (pop) begin
                occ_q <= occ_dec;
            end
        end
    end

    // Compare flags update on every edge they are written, stalled or not
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 3'b000;
        end else if (bus.flag_we) begin
            flags_q <= bus.flag_in;
        end
    end

    // Sticky error: a new error on the clearing edge must not be lost
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (bus.err_clr) begin
            err_q <= 1'b0;
        end
    end

    // Return-address storage write; no reset since occupancy alone defines validity
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[push_idx] <= pc_inc;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.flags     = flags_q;
    assign bus.taken     = taken_q;
    assign bus.err       = err_q;
    assign bus.ras_empty = stack_empty;
    assign bus.ras_full  = stack_full;

endmodule

// File: doc/branch_pc_unit.md
BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
REQ-001 Parameter PC_W, default 10, program-counter width in bits.
REQ-002 Parameter OFFSET_W, default 8, signed relative-branch offset width (OFFSET_W <= PC_W).
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries (>= 1).
REQ-004 Parameter START_ADDR, default 0, PC value loaded on reset.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 en  input  1  advance enable; low = stall.
REQ-008 cond_sel  input  2  branch condition, cond_t encoding: NONE=00, EQ=01, LT=10, GT=11.
REQ-009 abs_mode  input  1  0 = relative branch (pc+offset), 1 = absolute branch (target).
REQ-010 offset  input  OFFSET_W  signed two's-complement branch offset.
REQ-011 target  input  PC_W  absolute branch/call target.
REQ-012 call  input  1  function call (FUNC): push return address, jump to target.
REQ-013 ret  input  1  function return: pop return address.
REQ-014 flag_we  input  1  write compare flags.
REQ-015 flag_in  input  3  {gt, lt, eq} from CMP.
REQ-016 err_clr  input  1  clear sticky error.
REQ-017 pc  output  PC_W  current program counter.
REQ-018 flags  output  3  registered {gt, lt, eq}.
REQ-019 taken  output  1  one-cycle pulse: previous edge redirected PC.
REQ-020 ras_empty / ras_full  output  1 each  stack occupancy == 0 / == RAS_DEPTH.
REQ-021 err  output  1  sticky stack overflow/underflow/conflict error.

Function
REQ-022 Edge with en=1: exactly one action by priority: call&ret conflict > ret > call > taken branch > sequential.
REQ-023 Sequential: pc <= pc+1 mod 2^PC_W (wrap 2^PC_W-1 -> 0).
REQ-024 Branch taken iff cond_sel=EQ and flags.eq, LT and flags.lt, or GT and flags.gt; NONE never taken.
REQ-025 Condition evaluates against flags registered before this edge; same-edge flag_we not visible.
REQ-026 Taken relative: pc <= pc + sign-extended offset mod 2^PC_W; taken absolute: pc <= target.
REQ-027 Call, not full: push pc+1 (mod 2^PC_W), pc <= target; cond_sel/abs_mode ignored.
REQ-028 Call, full: no push, stack unchanged, pc <= target, err <= 1.
REQ-029 Ret, not empty: pop top, pc <= popped value (LIFO).
REQ-030 Ret, empty: pc <= pc+1, err <= 1.
REQ-031 call=ret=1: stack unchanged, pc <= pc+1, err <= 1.
REQ-032 taken <= 1 on next edge after taken branch, any call, or successful ret; else 0.
REQ-033 en=0: pc, stack, taken(<=0) hold; call/ret/branch ignored; flags and err still update.
REQ-034 flag_we=1: flags <= flag_in every edge regardless of en.
REQ-035 err_clr=1 clears err; a same-edge new error wins (err <= 1).
REQ-036 ras_empty/ras_full combinational from occupancy counter (0..RAS_DEPTH).

Reset
REQ-037 reset=1 asynchronously: pc=START_ADDR, flags=000, taken=0, err=0, occupancy=0 (ras_empty=1, ras_full=0); stack contents don't-care.
REQ-038 Reset mid-operation discards pending call/ret/branch; first action follows first edge with reset=0.

Verification (PC_W=10, OFFSET_W=8, RAS_DEPTH=4, START_ADDR=0)
REQ-039 Reset, en=1 1030 cycles, no control -> pc 0,1,...,1023,0,1...; taken stays 0.
REQ-040 pc=100, flags eq=1, cond_sel=EQ, abs_mode=0, offset=-4 -> pc=96, taken=1 next cycle; same with flags=000 -> pc=101, taken=0.
REQ-041 pc=50, cond_sel=LT, flag_we=1 flag_in lt=1 same edge, flags were 000 -> pc=51 (old flags used); next cycle taken branch.
REQ-042 call target=200 at pc=10, again at pc=200, then ret, ret -> pc 200,200,201,11; empty->ras_empty=1; 5th call from full -> err=1, ras_full stays 1, pc=target.
REQ-043 ret on empty stack at pc=7 -> pc=8, err=1; err_clr -> err=0; call=ret=1 -> pc+1, err=1, occupancy unchanged.
REQ-044 en=0 with call=1 -> pc, stack unchanged; reset during en=1 branch -> pc=0, flags=000, immediately (asynchronous).
